// File: rtl/exc_pkg.sv
// Shared types and encodings for the exception-entry/return sequencer and the
// CPSR/SPSR block it drives.
package exc_pkg;

  typedef enum logic [2:0] {IDLE, SAVE, MODE, LINK, VEC, RET} state_t;
  typedef enum logic [2:0] {NONE, FIQ, IRQ, UND, SVC} exc_t;

  localparam logic [2:0] WC_SPSR = 3'd0;
  localparam logic [2:0] WC_IRQ  = 3'd2;
  localparam logic [2:0] WC_FIQ  = 3'd3;
  localparam logic [2:0] WC_SVC  = 3'd4;
  localparam logic [2:0] WC_UND  = 3'd5;

  localparam logic [2:0] CM_NONE = 3'd0;
  localparam logic [2:0] CM_FIQ  = 3'd1;
  localparam logic [2:0] CM_IRQ  = 3'd2;
  localparam logic [2:0] CM_SVC  = 3'd3;
  localparam logic [2:0] CM_UND  = 3'd4;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_UND = 5'b11011;

  function automatic logic [2:0] change_m_of(exc_t e);
    case (e)
      FIQ:     return CM_FIQ;
      IRQ:     return CM_IRQ;
      SVC:     return CM_SVC;
      UND:     return CM_UND;
      default: return CM_NONE;
    endcase
  endfunction

  function automatic logic [2:0] w_cpsr_of(exc_t e);
    case (e)
      FIQ:     return WC_FIQ;
      IRQ:     return WC_IRQ;
      SVC:     return WC_SVC;
      UND:     return WC_UND;
      default: return WC_SPSR;
    endcase
  endfunction

  // Interrupts return past the interrupted instruction; UND/SVC link to it.
  function automatic logic link_plus4(exc_t e);
    return (e == FIQ) || (e == IRQ);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/exc_ctrl.sv
// Exception-entry/return sequencer: samples requests at instruction boundaries
// and steps the CPSR/SPSR block, banked LR and PC through entry or return.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_UND = 32'h0000_0004,
  parameter logic [31:0] VEC_SVC = 32'h0000_0008,
  parameter logic [31:0] VEC_IRQ = 32'h0000_0018,
  parameter logic [31:0] VEC_FIQ = 32'h0000_001C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic        fiq,
  input  logic        und_req,
  input  logic        svc_req,
  input  logic        exc_ret,
  input  logic        instr_done,
  input  logic [31:0] ret_addr,
  input  logic [31:0] CPSR,
  output logic        W_SPSR_s,
  output logic [2:0]  W_CPSR_s,
  output logic        Write_SPSR,
  output logic        Write_CPSR,
  output logic [2:0]  Change_M,
  output logic        lr_we,
  output logic [31:0] lr_data,
  output logic        pc_load,
  output logic [31:0] pc_vec,
  output logic        stall,
  output logic        ret_err
);

  state_t      state_q, state_d;
  exc_t        exc_q, exc_d;
  logic        err_q, err_d;
  logic        take;
  logic [31:0] addr_q;
  logic        irq_s, fiq_s;
  logic        unused_cpsr;

  assign unused_cpsr = ^{CPSR[31:8], CPSR[5]};

  sync_2ff u_sync_irq (.clk(clk), .rst(rst), .d(irq), .q(irq_s));
  sync_2ff u_sync_fiq (.clk(clk), .rst(rst), .d(fiq), .q(fiq_s));

  function automatic logic [31:0] vec_of(exc_t e);
    case (e)
      FIQ:     return VEC_FIQ;
      IRQ:     return VEC_IRQ;
      SVC:     return VEC_SVC;
      UND:     return VEC_UND;
      default: return 32'h0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exc_q   <= NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      err_q   <= err_d;
    end
  end

  // Link address is pure data: captured on entry, never needs a reset value.
  always_ff @(posedge clk) begin
    if (take) addr_q <= ret_addr;
  end

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    err_d   = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_done) begin
          if (exc_ret) begin
            if (CPSR[4:0] == MODE_USR) err_d = 1'b1;
            else                       state_d = RET;
          end else if (fiq_s && !CPSR[6]) begin
            state_d = SAVE; exc_d = FIQ; take = 1'b1;
          end else if (irq_s && !CPSR[7]) begin
            state_d = SAVE; exc_d = IRQ; take = 1'b1;
          end else if (und_req) begin
            state_d = SAVE; exc_d = UND; take = 1'b1;
          end else if (svc_req) begin
            state_d = SAVE; exc_d = SVC; take = 1'b1;
          end
        end
      end
      SAVE:    state_d = MODE;
      MODE:    state_d = LINK;
      LINK:    state_d = VEC;
      VEC:     state_d = IDLE;
      RET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    W_SPSR_s   = 1'b0;
    W_CPSR_s   = WC_SPSR;
    Write_SPSR = 1'b0;
    Write_CPSR = 1'b0;
    Change_M   = CM_NONE;
    lr_we      = 1'b0;
    lr_data    = 32'h0;
    pc_load    = 1'b0;
    pc_vec     = 32'h0;
    stall      = 1'b0;
    ret_err    = err_q;
    case (state_q)
      SAVE: begin
        stall      = 1'b1;
        Change_M   = change_m_of(exc_q);
        W_SPSR_s   = 1'b1;
        Write_SPSR = 1'b1;
      end
      MODE: begin
        stall      = 1'b1;
        Change_M   = change_m_of(exc_q);
        W_CPSR_s   = w_cpsr_of(exc_q);
        Write_CPSR = 1'b1;
      end
      LINK: begin
        stall   = 1'b1;
        lr_we   = 1'b1;
        lr_data = link_plus4(exc_q) ? addr_q + 32'd4 : addr_q;
      end
      VEC: begin
        stall   = 1'b1;
        pc_load = 1'b1;
        pc_vec  = vec_of(exc_q);
      end
      RET: begin
        stall      = 1'b1;
        Write_CPSR = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed vector table, mid-sequence reset and random
// requests checked cycle by cycle against a behavioural model.
module tb_exc_ctrl;

  localparam int K_NONE = 0;
  localparam int K_ENT  = 1;
  localparam int K_RET  = 2;
  localparam int K_ERR  = 3;

  typedef struct packed {
    logic        stall;
    logic        wsps;
    logic [2:0]  wcs;
    logic        wspsr;
    logic        wcpsr;
    logic [2:0]  cm;
    logic        lrwe;
    logic [31:0] lrd;
    logic        pcl;
    logic [31:0] pcv;
    logic        rerr;
  } out_t;

  typedef struct {
    logic        irq, fiq, und, svc, ret;
    logic [31:0] cpsr, ra;
    int          kind;
    logic [2:0]  cm, wcs;
    logic [31:0] lr, vec;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq, fiq, und_req, svc_req, exc_ret, instr_done;
  logic [31:0] ret_addr, CPSR;
  logic        W_SPSR_s, Write_SPSR, Write_CPSR, lr_we, pc_load, stall, ret_err;
  logic [2:0]  W_CPSR_s, Change_M;
  logic [31:0] lr_data, pc_vec;

  int n_chk  = 0;
  int n_pass = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .fiq(fiq), .und_req(und_req),
    .svc_req(svc_req), .exc_ret(exc_ret), .instr_done(instr_done),
    .ret_addr(ret_addr), .CPSR(CPSR), .W_SPSR_s(W_SPSR_s), .W_CPSR_s(W_CPSR_s),
    .Write_SPSR(Write_SPSR), .Write_CPSR(Write_CPSR), .Change_M(Change_M),
    .lr_we(lr_we), .lr_data(lr_data), .pc_load(pc_load), .pc_vec(pc_vec),
    .stall(stall), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o.stall = stall;  o.wsps = W_SPSR_s; o.wcs = W_CPSR_s; o.wspsr = Write_SPSR;
    o.wcpsr = Write_CPSR; o.cm = Change_M; o.lrwe = lr_we; o.lrd = lr_data;
    o.pcl = pc_load; o.pcv = pc_vec; o.rerr = ret_err;
    return o;
  endfunction

  task automatic chk(input string nm, input out_t act, input out_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Expected bus contents k cycles after the sampling edge, from a summary.
  function automatic out_t exp_at(input rec_t r, input int k);
    out_t o = '0;
    if (r.kind == K_ENT) begin
      case (k)
        0: begin o.stall = 1; o.cm = r.cm; o.wsps = 1; o.wspsr = 1; end
        1: begin o.stall = 1; o.cm = r.cm; o.wcs = r.wcs; o.wcpsr = 1; end
        2: begin o.stall = 1; o.lrwe = 1; o.lrd = r.lr; end
        3: begin o.stall = 1; o.pcl = 1; o.pcv = r.vec; end
        default: ;
      endcase
    end else if (r.kind == K_RET && k == 0) begin
      o.stall = 1; o.wcpsr = 1;
    end else if (r.kind == K_ERR && k == 0) begin
      o.rerr = 1;
    end
    return o;
  endfunction

  // Reference: priority rules applied to settled request levels.
  function automatic rec_t model(input rec_t r);
    rec_t m = r;
    logic [31:0] off = 0;
    m.kind = K_ENT; m.cm = 0; m.wcs = 0; m.lr = 0; m.vec = 0;
    if (r.ret) m.kind = (r.cpsr[4:0] == 5'b10000) ? K_ERR : K_RET;
    else if (r.fiq && !r.cpsr[6]) begin m.cm = 1; m.wcs = 3; m.vec = 32'h1C; off = 4; end
    else if (r.irq && !r.cpsr[7]) begin m.cm = 2; m.wcs = 2; m.vec = 32'h18; off = 4; end
    else if (r.und) begin m.cm = 4; m.wcs = 5; m.vec = 32'h04; end
    else if (r.svc) begin m.cm = 3; m.wcs = 4; m.vec = 32'h08; end
    else m.kind = K_NONE;
    if (m.kind == K_ENT) m.lr = r.ra + off;
    return m;
  endfunction

  task automatic run_vec(input string nm, input rec_t r);
    irq = r.irq; fiq = r.fiq; CPSR = r.cpsr; instr_done = 0;
    repeat (3) @(negedge clk);
    und_req = r.und; svc_req = r.svc; exc_ret = r.ret; ret_addr = r.ra;
    instr_done = 1;
    @(negedge clk);
    instr_done = 0; und_req = 0; svc_req = 0; exc_ret = 0;
    for (int k = 0; k <= 4; k++) begin
      chk($sformatf("%s_c%0d", nm, k), sample(), exp_at(r, k));
      @(negedge clk);
    end
  endtask

  rec_t tbl[12];
  rec_t r;
  out_t e;

  initial begin
    // irq fiq und svc ret cpsr ra | kind cm wcs lr vec
    tbl[0]  = '{1,0,0,0,0, 32'h10, 32'h100,        K_ENT, 3'd2, 3'd2, 32'h104, 32'h18};
    tbl[1]  = '{1,1,0,0,0, 32'h10, 32'h100,        K_ENT, 3'd1, 3'd3, 32'h104, 32'h1C};
    tbl[2]  = '{1,1,0,0,0, 32'h50, 32'h100,        K_ENT, 3'd2, 3'd2, 32'h104, 32'h18};
    tbl[3]  = '{1,0,0,1,0, 32'h90, 32'h200,        K_ENT, 3'd3, 3'd4, 32'h200, 32'h08};
    tbl[4]  = '{0,0,0,0,1, 32'h12, 32'h0,          K_RET, 3'd0, 3'd0, 32'h0,   32'h0};
    tbl[5]  = '{0,0,0,0,1, 32'h10, 32'h0,          K_ERR, 3'd0, 3'd0, 32'h0,   32'h0};
    tbl[6]  = '{0,0,1,0,0, 32'h13, 32'h300,        K_ENT, 3'd4, 3'd5, 32'h300, 32'h04};
    tbl[7]  = '{1,0,0,0,0, 32'h10, 32'hFFFF_FFFC,  K_ENT, 3'd2, 3'd2, 32'h0,   32'h18};
    tbl[8]  = '{1,1,1,0,0, 32'h10, 32'h80,         K_ENT, 3'd1, 3'd3, 32'h84,  32'h1C};
    tbl[9]  = '{0,0,0,0,0, 32'h10, 32'h80,         K_NONE,3'd0, 3'd0, 32'h0,   32'h0};
    tbl[10] = '{1,0,0,0,1, 32'h12, 32'h80,         K_RET, 3'd0, 3'd0, 32'h0,   32'h0};
    tbl[11] = '{0,1,0,1,0, 32'hD0, 32'h40,         K_ENT, 3'd3, 3'd4, 32'h40,  32'h08};

    rst = 1; irq = 0; fiq = 0; und_req = 0; svc_req = 0; exc_ret = 0;
    instr_done = 0; ret_addr = 0; CPSR = 32'h10;
    repeat (2) @(negedge clk);
    chk("reset", sample(), '0);
    rst = 0;

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Reset while in LINK aborts the sequence at once.
    irq = 1; fiq = 0; CPSR = 32'h10; ret_addr = 32'h100;
    repeat (3) @(negedge clk);
    instr_done = 1;
    @(negedge clk);
    instr_done = 0;
    repeat (2) @(negedge clk);
    e = '0; e.stall = 1; e.lrwe = 1; e.lrd = 32'h104;
    chk("link_pre_rst", sample(), e);
    rst = 1; irq = 0;
    #1 chk("rst_mid", sample(), '0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_idle", sample(), '0);
    r = '{0,0,1,0,0, 32'h10, 32'h500, K_ENT, 3'd4, 3'd5, 32'h500, 32'h04};
    run_vec("und_after_rst", r);

    for (int i = 0; i < 40; i++) begin
      r.irq = 1'($urandom_range(0, 1)); r.fiq = 1'($urandom_range(0, 1));
      r.und = 1'($urandom_range(0, 1)); r.svc = 1'($urandom_range(0, 1));
      r.ret = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 4))
        0: r.cpsr = 32'h10;
        1: r.cpsr = 32'h11;
        2: r.cpsr = 32'h12;
        3: r.cpsr = 32'h13;
        default: r.cpsr = 32'h1B;
      endcase
      r.cpsr[6] = 1'($urandom_range(0, 1));
      r.cpsr[7] = 1'($urandom_range(0, 1));
      r.ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      run_vec($sformatf("rnd%0d", i), model(r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
